// File: rtl/regwr_arbdec.sv
// regwr_arbdec: merges two writeback request ports onto one register-file
// write port and decodes the winner into a registered one-hot enable.
//   Port A (ALU)  : highest priority, never stalled.
//   Port B (load) : buffered in a DEPTH-entry FIFO, ready/valid handshake.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   a_valid_i/a_sel_i/a_data_i     port-A write request
//   b_valid_i/b_sel_i/b_data_i     port-B write request
//   b_ready_o                      port B accepted this cycle (combinational)
//   we_o                           registered one-hot write enable (2**SEL_W)
//   wsel_o/wdata_o/wsrc_o          registered select/data/source (0=A, 1=B)
//   pend_cnt_o                     FIFO occupancy, 0..DEPTH
module regwr_arbdec #(
  parameter int SEL_W   = 4,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 2,
  parameter int ZERO_RO = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      a_valid_i,
  input  logic [SEL_W-1:0]          a_sel_i,
  input  logic [DATA_W-1:0]         a_data_i,
  input  logic                      b_valid_i,
  input  logic [SEL_W-1:0]          b_sel_i,
  input  logic [DATA_W-1:0]         b_data_i,
  output logic                      b_ready_o,
  output logic [(1<<SEL_W)-1:0]     we_o,
  output logic [SEL_W-1:0]          wsel_o,
  output logic [DATA_W-1:0]         wdata_o,
  output logic                      wsrc_o,
  output logic [$clog2(DEPTH):0]    pend_cnt_o
);

  localparam int N     = 1 << SEL_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [SEL_W-1:0]  fifo_sel_q  [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N-1:0]      we_q, we_d;
  logic [SEL_W-1:0]  wsel_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wsrc_q;

  logic              fifo_empty, b_acc, push, pop;
  logic              iss;
  logic [SEL_W-1:0]  iss_sel;
  logic [DATA_W-1:0] iss_data;
  logic              iss_src;

  // Ready depends only on the registered occupancy, so a pop in the same
  // cycle never opens room for a push: a full FIFO stays closed for one cycle.
  assign b_ready_o  = !rst_i && (cnt_q != FULL_CNT);
  assign b_acc      = b_valid_i && b_ready_o;
  assign fifo_empty = (cnt_q == '0);

  // Arbitration: A, then the queued head, then a direct B bypass. A newly
  // accepted B is only bypassed when nothing is queued, keeping B in order.
  always_comb begin
    iss      = 1'b0;
    iss_sel  = '0;
    iss_data = '0;
    iss_src  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    if (a_valid_i) begin
      iss      = 1'b1;
      iss_sel  = a_sel_i;
      iss_data = a_data_i;
      iss_src  = 1'b0;
      push     = b_acc;
    end else if (!fifo_empty) begin
      iss      = 1'b1;
      iss_sel  = fifo_sel_q[rd_ptr_q];
      iss_data = fifo_data_q[rd_ptr_q];
      iss_src  = 1'b1;
      pop      = 1'b1;
      push     = b_acc;
    end else if (b_acc) begin
      iss      = 1'b1;
      iss_sel  = b_sel_i;
      iss_data = b_data_i;
      iss_src  = 1'b1;
    end
  end

  // Select 0 is still issued when hard-wired to zero; only the enable is dropped.
  always_comb begin
    we_d = '0;
    if (iss && !((ZERO_RO != 0) && (iss_sel == '0))) begin
      we_d[iss_sel] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q     <= '0;
      wsel_q   <= '0;
      wdata_q  <= '0;
      wsrc_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      we_q <= we_d;
      if (iss) begin
        wsel_q  <= iss_sel;
        wdata_q <= iss_data;
        wsrc_q  <= iss_src;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_sel_q[wr_ptr_q]  <= b_sel_i;
      fifo_data_q[wr_ptr_q] <= b_data_i;
    end
  end

  assign we_o       = we_q;
  assign wsel_o     = wsel_q;
  assign wdata_o    = wdata_q;
  assign wsrc_o     = wsrc_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: doc/regwr_arbdec.md
Name: regwr_arbdec

Overview:
- Parametrised, registered successor to the 4x16 register-select demux.
- Merges two writeback request ports into the single register-file write port:
  - port A: ALU writeback, highest priority, never stalled.
  - port B: load writeback, buffered in a small FIFO, with ready backpressure.
- Decodes the winning select into a registered one-hot write-enable vector and steers the matching data, so the register file sees at most one write per cycle.
- Optional hard-wired-zero register R0.

Parameters:
- SEL_W, 4: select width; register count N = 2**SEL_W.
- DATA_W, 16: writeback data width.
- DEPTH, 2: port-B pending FIFO depth; power of two, at least 2.
- ZERO_RO, 1: when 1, writes to select 0 are accepted but never produce an enable pulse.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  port-A write request.
- a_sel  in  SEL_W  port-A destination register.
- a_data  in  DATA_W  port-A write data.
- b_valid  in  1  port-B write request.
- b_sel  in  SEL_W  port-B destination register.
- b_data  in  DATA_W  port-B write data.
- b_ready  out  1  port B accepts this cycle; combinational = !rst && !fifo_full.
- we  out  N  registered one-hot write enable to the register file.
- wsel  out  SEL_W  registered select of the issued write.
- wdata  out  DATA_W  registered data of the issued write.
- wsrc  out  1  registered source of the issued write; 0 = A, 1 = B.
- pend_cnt  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - we, wsel, wdata, wsrc and pend_cnt go to 0; FIFO pointers go to 0.
  - Any in-flight or queued B entries are discarded.
  - b_ready is 0 while rst is high.
- Port-B handshake: a B write is accepted on an edge where b_valid && b_ready. Port A is accepted whenever a_valid is high.
- Arbitration, once per cycle, in priority order:
  1. a_valid: issue A. An accepted B is pushed to the FIFO.
  2. FIFO non-empty: issue the FIFO head (pop). An accepted B is pushed.
  3. FIFO empty and B accepted: issue B directly (bypass, no enqueue).
  4. Otherwise no issue.
- Ordering: B writes issue strictly in acceptance order. A new B never bypasses queued entries.
- Issue latency: 1 cycle. An issue decided at edge k makes we[sel]=1, wsel, wdata and wsrc valid for the cycle after edge k. With no issue, we=0, and wsel/wdata/wsrc hold their last values.
- One-hot rule: at most one bit of we is ever set. we[i]=1 iff issued sel==i, except sel==0 with ZERO_RO=1, which gives we=0 (wsel/wdata/wsrc still update).
- Full FIFO: b_ready=0, so no push occurs even if a pop happens the same cycle. b_ready rises the cycle after occupancy drops below DEPTH.
- Simultaneous push and pop (FIFO not full): occupancy is unchanged and pointers both advance.
- Pointers wrap modulo DEPTH. pend_cnt ranges 0..DEPTH.
- Same register: A and B targeting the same register in one cycle is legal. A issues first and B follows, so B's value is the final one. No merging.
- Starvation: B is stalled indefinitely while a_valid stays high. This is intended; the bench checks that no B entry is lost.

Test Plan:
- Reset/idle: hold rst 3 cycles with a_valid=b_valid=1 -> we=0, pend_cnt=0, b_ready=0 throughout. Release rst -> b_ready=1 next cycle.
- Decode sweep: A only, a_sel=0..15, a_data=0x1000+i, one per cycle -> next cycle we=1<<i and wdata=0x1000+i for i=1..15. For i=0, we=0 with wsel=0 (ZERO_RO=1). Rerun with ZERO_RO=0 -> i=0 gives we=0x0001.
- Bypass: FIFO empty, A idle, b_valid with b_sel=5, b_data=0xBEEF -> next cycle we=0x0020, wsrc=1, wdata=0xBEEF, pend_cnt=0.
- Contention and ordering: A valid every cycle for 4 cycles with sel=1,2,3,4. B offers sel=9 then sel=10 -> B accepted twice, pend_cnt=2, b_ready=0. A third B is held off. After A stops, issues are sel 9 then 10 (wsrc=1) in order, and b_ready returns to 1.
- Full with simultaneous pop: FIFO full (DEPTH=2), A idle, b_valid held -> first cycle pops the head with no push (pend_cnt=1). The following cycle pushes and pops together (pend_cnt stays 1). No B value lost or duplicated; compared against a scoreboard.
- Reset mid-operation: pend_cnt=2 with an issue pending, assert rst one cycle -> next cycle we=0 and pend_cnt=0. Queued B entries never appear on we.
